// File: rtl/seg_formatter.sv
// Signed result to four 7-segment digit patterns, using a sequential double-dabble conversion.
// A start/done handshake drives the conversion, and the digits hold the last result.
module seg_formatter #(
  parameter bit LEADING_BLANK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] value,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  digit1,
  output logic [7:0]  digit2,
  output logic [7:0]  digit3,
  output logic [7:0]  digit4
);

  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_R     = 8'hAF;
  localparam logic [3:0] LAST_SHIFT = 4'd13;

  typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;

  state_t          state_q, state_d;
  logic            load, shift_en, encode_en;

  logic            sign_q, sign_d;
  logic            range_err_q, range_err_d;
  logic [14:0]     mag_q, mag_d;
  logic [15:0]     bcd_q, bcd_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0][7:0] digits_q, digits_d;
  logic            err_q, err_d;
  logic            done_q, done_d;

  logic [14:0]     value_ext;
  logic [15:0]     bcd_adj;
  logic [3:0][7:0] enc;
  logic            blank4, blank3, blank2;

  function automatic logic [7:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0:    seg_of = 8'hC0;
      4'd1:    seg_of = 8'hF9;
      4'd2:    seg_of = 8'hA4;
      4'd3:    seg_of = 8'hB0;
      4'd4:    seg_of = 8'h99;
      4'd5:    seg_of = 8'h92;
      4'd6:    seg_of = 8'h82;
      4'd7:    seg_of = 8'hF8;
      4'd8:    seg_of = 8'h80;
      4'd9:    seg_of = 8'h90;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so no path through this block leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST_SHIFT) state_d = ENCODE;
      ENCODE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    load      = (state_q == IDLE) && start;
    shift_en  = (state_q == SHIFT);
    encode_en = (state_q == ENCODE);
  end

  // Add-3 correction on every nibble before each shift.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
  end

  // Leading-zero blanking chains down from the thousands position; the ones digit is always shown.
  always_comb begin
    blank4 = LEADING_BLANK && (bcd_q[15:12] == 4'd0);
    blank3 = blank4 && (bcd_q[11:8] == 4'd0);
    blank2 = blank3 && (bcd_q[7:4] == 4'd0);
    enc[3] = blank4 ? SEG_BLANK : seg_of(bcd_q[15:12]);
    enc[2] = blank3 ? SEG_BLANK : seg_of(bcd_q[11:8]);
    enc[1] = blank2 ? SEG_BLANK : seg_of(bcd_q[7:4]);
    enc[0] = seg_of(bcd_q[3:0]);
    if (sign_q) begin
      if (!LEADING_BLANK || !blank3) enc[3] = SEG_MINUS;
      else if (!blank2)              enc[2] = SEG_MINUS;
      else                           enc[1] = SEG_MINUS;
    end
    if (range_err_q) enc = {SEG_E, SEG_R, SEG_R, SEG_BLANK};
  end

  always_comb begin
    value_ext   = {value[13], value};
    sign_d      = sign_q;
    range_err_d = range_err_q;
    mag_d       = mag_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    digits_d    = digits_q;
    err_d       = err_q;
    done_d      = 1'b0;
    if (load) begin
      sign_d      = value[13];
      mag_d       = value[13] ? (~value_ext + 15'd1) : value_ext;
      range_err_d = ($signed(value) < -14'sd999);
      bcd_d       = '0;
      cnt_d       = '0;
    end
    if (shift_en) begin
      bcd_d = {bcd_adj[14:0], mag_q[13]};
      mag_d = {mag_q[13:0], 1'b0};
      cnt_d = cnt_q + 4'd1;
    end
    if (encode_en) begin
      digits_d = enc;
      err_d    = range_err_q;
      done_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sign_q      <= 1'b0;
      range_err_q <= 1'b0;
      mag_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      digits_q    <= {SEG_BLANK, SEG_BLANK, SEG_BLANK, 8'hC0};
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      sign_q      <= sign_d;
      range_err_q <= range_err_d;
      mag_q       <= mag_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      digits_q    <= digits_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  assign done   = done_q;
  assign err    = err_q;
  assign digit1 = digits_q[0];
  assign digit2 = digits_q[1];
  assign digit3 = digits_q[2];
  assign digit4 = digits_q[3];

endmodule

// File: tb/tb_seg_formatter.sv
// Self-checking bench for seg_formatter: both blanking variants run side by side, with a
// scoreboard of expected digits/err and the done cycle pushed at start and popped at done.
module tb_seg_formatter;

  logic        clk, rst, start;
  logic [13:0] value;
  logic        busy1, done1, err1, busy0, done0, err0;
  logic [7:0]  d1_1, d2_1, d3_1, d4_1, d1_0, d2_0, d3_0, d4_0;

  seg_formatter #(.LEADING_BLANK(1'b1)) dut_lb1 (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy1), .done(done1), .err(err1),
    .digit1(d1_1), .digit2(d2_1), .digit3(d3_1), .digit4(d4_1)
  );

  seg_formatter #(.LEADING_BLANK(1'b0)) dut_lb0 (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy0), .done(done0), .err(err0),
    .digit1(d1_0), .digit2(d2_0), .digit3(d3_0), .digit4(d4_0)
  );

  typedef struct {
    logic [32:0] r1;
    logic [32:0] r0;
    int          due;
    int          val;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          busy_cnt = 0;
  logic [31:0] held;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] seg_code(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // Decimal reference model: returns {err, digit4, digit3, digit2, digit1}.
  function automatic logic [32:0] model(input int v, input bit lb);
    int         m, msd;
    int         d[4];
    logic [7:0] s[4];
    bit         neg;
    if (v < -999) return {1'b1, 8'h86, 8'hAF, 8'hAF, 8'hFF};
    neg  = (v < 0);
    m    = neg ? -v : v;
    d[0] = m % 10;
    d[1] = (m / 10) % 10;
    d[2] = (m / 100) % 10;
    d[3] = m / 1000;
    for (int i = 0; i < 4; i++) s[i] = seg_code(d[i]);
    if (lb) begin
      msd = 0;
      for (int i = 1; i < 4; i++) if (d[i] != 0) msd = i;
      for (int i = msd + 1; i < 4; i++) s[i] = 8'hFF;
      if (neg) s[msd + 1] = 8'hBF;
    end else if (neg) begin
      s[3] = 8'hBF;
    end
    return {1'b0, s[3], s[2], s[1], s[0]};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      busy_cnt = 0;
    end else begin
      if (busy1) begin
        busy_cnt++;
        check("hold_during_busy", {d4_1, d3_1, d2_1, d1_1}, held);
      end
      if (sb.size() == 0) begin
        check("no_done_lb1", done1, 1'b0);
        check("no_done_lb0", done0, 1'b0);
      end else if (done1) begin
        exp_t e;
        e = sb.pop_front();
        check("latency", cyc, e.due);
        check("busy_cycles", busy_cnt, 15);
        check("done_lb0", done0, 1'b1);
        check($sformatf("result_lb1 v=%0d", e.val), {err1, d4_1, d3_1, d2_1, d1_1}, e.r1);
        check($sformatf("result_lb0 v=%0d", e.val), {err0, d4_0, d3_0, d2_0, d1_0}, e.r0);
        busy_cnt = 0;
      end
    end
    if (!busy1) held = {d4_1, d3_1, d2_1, d1_1};
  end

  // Called #1 after a rising edge; start is sampled at the next edge (E0), done visible after E15.
  task automatic start_conv(input int v);
    exp_t e;
    e.r1  = model(v, 1'b1);
    e.r0  = model(v, 1'b0);
    e.due = cyc + 16;
    e.val = v;
    sb.push_back(e);
    start = 1'b1;
    value = 14'(v);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1 seen = done1;
    end
    if (!seen) begin
      check("done_timeout", 1'b0, 1'b1);
      sb.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_digits_lb1", {d4_1, d3_1, d2_1, d1_1}, 32'hFFFF_FFC0);
    check("rst_digits_lb0", {d4_0, d3_0, d2_0, d1_0}, 32'hFFFF_FFC0);
    check("rst_busy", busy1, 1'b0);
    check("rst_done", done1, 1'b0);
    check("rst_err", err1, 1'b0);
    rst = 1'b1;
  endtask

  int vec[] = '{1234, 7, 0, 8191, -5, -999, -1000, -8192, 42, 1005, -50, -100, 100, 9, -1, 8000};

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    value = '0;
    #1;
    do_reset();
    repeat (20) @(posedge clk);
    #1;

    foreach (vec[i]) begin
      start_conv(vec[i]);
      wait_done();
      repeat (2) @(posedge clk);
      #1;
    end

    for (int i = 0; i < 6; i++) begin
      int v;
      if (i == 5) v = -999 - int'($urandom_range(1, 7193));
      else        v = int'($urandom_range(0, 9190)) - 999;
      start_conv(v);
      wait_done();
      @(posedge clk);
      #1;
    end

    // A start arriving mid-conversion is dropped.
    start_conv(321);
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    value = 14'(-8000);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    repeat (20) @(posedge clk);
    #1;

    // Reset partway through a conversion: reset values, no done afterwards.
    start_conv(555);
    repeat (7) @(posedge clk);
    #1;
    do_reset();
    repeat (25) @(posedge clk);
    #1;

    // Back-to-back: start in the done cycle is accepted.
    start_conv(-42);
    wait_done();
    start_conv(6789);
    wait_done();
    start_conv(-1000);
    wait_done();
    repeat (3) @(posedge clk);
    #1;

    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
